// File: rtl/pcs_block_sync.sv
// rtl/pcs_block_sync.sv - 64b/66b receive block synchroniser with hunt/lock/slip-wait FSM
module pcs_block_sync #(
    parameter int DATA_WIDTH      = 64,
    parameter int SH_CNT_MAX      = 64,
    parameter int SH_INVLD_MAX    = 16,
    parameter int SLIP_WAIT_BEATS = 4,
    parameter int PASS_UNLOCKED   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_header,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_header,
    output logic                  out_valid,
    output logic                  out_block_lock,
    output logic                  out_slip,
    output logic [15:0]           out_slip_count
);

    localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT_BEATS + 1);

    typedef enum logic [1:0] {HUNT, LOCKED, SLIP_WAIT} state_t;

    state_t            state, state_nxt;
    logic [SH_W-1:0]   sh_cnt, sh_cnt_nxt, sh_inc;
    logic [INV_W-1:0]  invld_cnt, invld_cnt_nxt, invld_inc;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt, wait_inc;
    logic [15:0]       slip_cnt;
    logic              lock_nxt, slip_nxt, hdr_ok;

    assign hdr_ok         = in_header[1] ^ in_header[0];
    assign sh_inc         = sh_cnt + 1'b1;
    assign invld_inc      = invld_cnt + 1'b1;
    assign wait_inc       = wait_cnt + 1'b1;
    assign out_slip_count = slip_cnt;

    always_comb begin
        state_nxt     = state;
        sh_cnt_nxt    = sh_cnt;
        invld_cnt_nxt = invld_cnt;
        wait_cnt_nxt  = wait_cnt;
        lock_nxt      = out_block_lock;
        slip_nxt      = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (!hdr_ok) begin
                        slip_nxt     = 1'b1;
                        sh_cnt_nxt   = '0;
                        wait_cnt_nxt = '0;
                        state_nxt    = SLIP_WAIT;
                    end else if (sh_inc == SH_W'(SH_CNT_MAX)) begin
                        lock_nxt      = 1'b1;
                        sh_cnt_nxt    = '0;
                        invld_cnt_nxt = '0;
                        state_nxt     = LOCKED;
                    end else begin
                        sh_cnt_nxt = sh_inc;
                    end
                end
                LOCKED: begin
                    // Loss of lock wins over a window rollover on the same beat
                    if (!hdr_ok && invld_inc == INV_W'(SH_INVLD_MAX)) begin
                        lock_nxt      = 1'b0;
                        slip_nxt      = 1'b1;
                        sh_cnt_nxt    = '0;
                        invld_cnt_nxt = '0;
                        wait_cnt_nxt  = '0;
                        state_nxt     = SLIP_WAIT;
                    end else if (sh_inc == SH_W'(SH_CNT_MAX)) begin
                        sh_cnt_nxt    = '0;
                        invld_cnt_nxt = '0;
                    end else begin
                        sh_cnt_nxt = sh_inc;
                        if (!hdr_ok) invld_cnt_nxt = invld_inc;
                    end
                end
                SLIP_WAIT: begin
                    lock_nxt = 1'b0;
                    if (wait_inc == WAIT_W'(SLIP_WAIT_BEATS)) begin
                        wait_cnt_nxt  = '0;
                        sh_cnt_nxt    = '0;
                        invld_cnt_nxt = '0;
                        state_nxt     = HUNT;
                    end else begin
                        wait_cnt_nxt = wait_inc;
                    end
                end
                default: begin
                    lock_nxt  = 1'b0;
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= HUNT;
            sh_cnt         <= '0;
            invld_cnt      <= '0;
            wait_cnt       <= '0;
            slip_cnt       <= '0;
            out_block_lock <= 1'b0;
            out_slip       <= 1'b0;
        end else begin
            state          <= state_nxt;
            sh_cnt         <= sh_cnt_nxt;
            invld_cnt      <= invld_cnt_nxt;
            wait_cnt       <= wait_cnt_nxt;
            out_block_lock <= lock_nxt;
            out_slip       <= slip_nxt;
            if (slip_nxt && slip_cnt != 16'hFFFF) slip_cnt <= slip_cnt + 16'd1;
        end
    end

    // Qualifier uses the lock status seen before this beat's update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_header <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= in_valid & (out_block_lock | (PASS_UNLOCKED != 0));
            if (in_valid) begin
                out_data   <= in_data;
                out_header <= in_header;
            end
        end
    end

endmodule

// File: tb/tb_pcs_block_sync.sv
// tb/tb_pcs_block_sync.sv - directed self-checking bench for pcs_block_sync
module tb_pcs_block_sync;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [1:0]  in_header;
    logic        in_valid;
    logic [63:0] out_data;
    logic [1:0]  out_header;
    logic        out_valid;
    logic        out_block_lock;
    logic        out_slip;
    logic [15:0] out_slip_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          slip_pulses = 0;
    logic [63:0] last_data;

    pcs_block_sync dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_header      (in_header),
        .in_valid       (in_valid),
        .out_data       (out_data),
        .out_header     (out_header),
        .out_valid      (out_valid),
        .out_block_lock (out_block_lock),
        .out_slip       (out_slip),
        .out_slip_count (out_slip_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [1:0] h, input logic v);
        in_header = h;
        in_valid  = v;
        in_data   = {$urandom, $urandom};
        if (v) last_data = in_data;
        @(posedge clk);
        #1;
        if (out_slip) slip_pulses++;
    endtask

    task automatic run(input int n, input logic [1:0] h);
        for (int i = 0; i < n; i++) beat(h, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  out_data, 64'd0);
        check({tag, "_hdr"},   64'(out_header), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_lock"},  64'(out_block_lock), 64'd0);
        check({tag, "_slip"},  64'(out_slip), 64'd0);
        check({tag, "_cnt"},   64'(out_slip_count), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_header = 2'b00; in_valid = 1'b0; last_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Clean lock
        beat(2'b01, 1'b1);
        check("first_data", out_data, last_data);
        check("first_hdr", 64'(out_header), 64'd1);
        check("first_valid_unlocked", 64'(out_valid), 64'd0);
        run(62, 2'b01);
        check("lock_after_63", 64'(out_block_lock), 64'd0);
        beat(2'b01, 1'b1);
        check("lock_after_64", 64'(out_block_lock), 64'd1);
        check("valid_beat64", 64'(out_valid), 64'd0);
        beat(2'b10, 1'b1);
        check("valid_beat65", 64'(out_valid), 64'd1);
        check("data_beat65", out_data, last_data);
        check("hdr_beat65", 64'(out_header), 64'd2);
        check("clean_no_slip", 64'(slip_pulses), 64'd0);
        run(63, 2'b01);

        // 15 invalid per window, two windows
        for (int w = 0; w < 2; w++) begin
            run(15, 2'b00);
            run(49, 2'b01);
        end
        check("lock_15_per_window", 64'(out_block_lock), 64'd1);

        // Rollover: 15 invalid at end of window, 1 early in the next
        run(49, 2'b01);
        run(15, 2'b11);
        run(1, 2'b00);
        run(63, 2'b01);
        check("lock_rollover", 64'(out_block_lock), 64'd1);
        check("rollover_no_slip", 64'(slip_pulses), 64'd0);

        // 16th invalid lands on window end: loss of lock takes priority
        run(48, 2'b01);
        run(15, 2'b00);
        check("lock_after_15_invalid", 64'(out_block_lock), 64'd1);
        beat(2'b00, 1'b1);
        check("lol_lock", 64'(out_block_lock), 64'd0);
        check("lol_slip", 64'(out_slip), 64'd1);
        check("lol_count", 64'(out_slip_count), 64'd1);
        beat(2'b00, 1'b0);
        check("slip_one_cycle", 64'(out_slip), 64'd0);
        run(4, 2'b00);
        check("wait_no_slip", 64'(slip_pulses), 64'd1);

        // Hunt slip on beat 10, then 4 ignored beats
        run(9, 2'b01);
        beat(2'b00, 1'b1);
        check("hunt_slip", 64'(out_slip), 64'd1);
        check("hunt_count", 64'(out_slip_count), 64'd2);
        run(4, 2'b01);
        run(63, 2'b01);
        check("hunt_lock_63", 64'(out_block_lock), 64'd0);
        beat(2'b01, 1'b1);
        check("hunt_lock_64", 64'(out_block_lock), 64'd1);
        check("hunt_pulses", 64'(slip_pulses), 64'd2);

        // Lose lock, then hunt with in_valid gaps
        run(16, 2'b00);
        check("gap_lol", 64'(out_slip_count), 64'd3);
        for (int i = 0; i < 4; i++) begin
            beat(2'b00, 1'b1);
            beat(2'b00, 1'b0);
        end
        for (int i = 0; i < 63; i++) begin
            beat(2'b01, 1'b1);
            beat(2'b00, 1'b0);
        end
        check("gap_lock_63", 64'(out_block_lock), 64'd0);
        check("gap_idle_valid", 64'(out_valid), 64'd0);
        beat(2'b01, 1'b1);
        check("gap_lock_64", 64'(out_block_lock), 64'd1);
        beat(2'b00, 1'b0);
        check("gap_idle_slip", 64'(out_slip), 64'd0);
        check("gap_pulses", 64'(slip_pulses), 64'd3);

        // Async reset while locked
        #3 rst_n = 1'b0;
        #1 check_all_zero("arst_locked");
        @(posedge clk); #1 rst_n = 1'b1;
        run(63, 2'b01);
        check("relock_63", 64'(out_block_lock), 64'd0);
        beat(2'b01, 1'b1);
        check("relock_64", 64'(out_block_lock), 64'd1);

        // Async reset with a slip pulse in flight
        run(16, 2'b00);
        check("inflight_slip", 64'(out_slip), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("arst_slip");
        @(posedge clk); #1 rst_n = 1'b1;
        beat(2'b01, 1'b1);
        check("post_rst_slip", 64'(out_slip), 64'd0);
        run(62, 2'b01);
        check("relock2_63", 64'(out_block_lock), 64'd0);
        beat(2'b01, 1'b1);
        check("relock2_64", 64'(out_block_lock), 64'd1);

        // Saturation of slip counter from a preloaded near-full value
        force dut.slip_cnt = 16'hFFFD;
        #1 release dut.slip_cnt;
        run(16, 2'b00);
        check("sat_fffe", 64'(out_slip_count), 64'hFFFE);
        run(4, 2'b00);
        beat(2'b00, 1'b1);
        check("sat_ffff", 64'(out_slip_count), 64'hFFFF);
        run(4, 2'b00);
        beat(2'b00, 1'b1);
        check("sat_slip", 64'(out_slip), 64'd1);
        check("sat_hold", 64'(out_slip_count), 64'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
